// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: one A/B detent of 10 phases x T cycles per accepted step, ready only while idle.
// Define QUAD_EMU_BOUNCE_EN to add LFSR contact bounce on the four edge phases (settled value in each phase's last cycle).
module quad_encoder_emulator #(
    parameter int CLOCK_FREQ_MHZ = 100,
    parameter int DELAY_IN_US    = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_valid_i,
    input  logic step_dir_i,
    output logic step_ready_o,
    output logic done_o,
    output logic a_o,
    output logic b_o
);

    localparam int T  = CLOCK_FREQ_MHZ * DELAY_IN_US;
    localparam int CW = $clog2(T);
    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [3:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          a_q, b_q, a_d, b_d;
    logic          done_q, ready_q;
    logic          phase_end, detent_end;
    logic          lead_d, foll_d;
    logic          bnc0, bnc1;

`ifdef QUAD_EMU_BOUNCE_EN
    logic [15:0] lfsr_q;
    logic        last_d;

    // Free-running in every state so the noise pattern never depends on step timing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign last_d = (cnt_d == CNT_LAST);
    assign bnc0   = last_d ? 1'b0 : lfsr_q[0];
    assign bnc1   = last_d ? 1'b1 : lfsr_q[0];
`else
    assign bnc0 = 1'b0;
    assign bnc1 = 1'b1;
`endif

    assign phase_end  = (cnt_q == CNT_LAST);
    assign detent_end = (state_q == RUN) && phase_end && (phase_q == 4'd9);

    // Position of the cycle about to be registered; outputs are computed from it so they stay registered.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (state_q == IDLE) begin
            phase_d = 4'd0;
            cnt_d   = '0;
            dir_d   = step_dir_i;
        end else if (phase_end) begin
            cnt_d   = '0;
            phase_d = (phase_q == 4'd9) ? 4'd9 : phase_q + 4'd1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        lead_d = 1'b1;
        foll_d = 1'b1;
        case (phase_d)
            4'd0:        begin lead_d = bnc0; foll_d = 1'b1; end
            4'd1, 4'd2:  begin lead_d = 1'b0; foll_d = 1'b1; end
            4'd3:        begin lead_d = 1'b0; foll_d = bnc0; end
            4'd4, 4'd5:  begin lead_d = 1'b0; foll_d = 1'b0; end
            4'd6:        begin lead_d = bnc1; foll_d = 1'b0; end
            4'd7, 4'd8:  begin lead_d = 1'b1; foll_d = 1'b0; end
            4'd9:        begin lead_d = 1'b1; foll_d = bnc1; end
            default:     begin lead_d = 1'b1; foll_d = 1'b1; end
        endcase
        a_d = dir_d ? lead_d : foll_d;
        b_d = dir_d ? foll_d : lead_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            phase_q <= 4'd0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (step_valid_i) begin
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        dir_q   <= dir_d;
                        phase_q <= phase_d;
                        cnt_q   <= cnt_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                    end
                end
                RUN: begin
                    if (detent_end) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        phase_q <= 4'd0;
                        cnt_q   <= '0;
                        a_q     <= 1'b1;
                        b_q     <= 1'b1;
                    end else begin
                        phase_q <= phase_d;
                        cnt_q   <= cnt_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                    end
                end
            endcase
        end
    end

    assign step_ready_o = ready_q;
    assign done_o       = done_q;
    assign a_o          = a_q;
    assign b_o          = b_q;

endmodule
